// File: rtl/run_seq_pkg.sv
// Shared types and width helpers for the run/reset sequencer.
package run_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val <= 32'd1) ? 32'd1 : 32'($clog2(max_val + 32'd1));
    endfunction

    function automatic int unsigned hold_cnt_w(input int unsigned rst_cycles);
        return cnt_w(rst_cycles);
    endfunction

    function automatic int unsigned run_cnt_w(input int unsigned timeout);
        return cnt_w(timeout);
    endfunction

endpackage

// File: rtl/run_sequencer.sv
// Run/reset controller: stretches reset into a core reset, enables the algorithm
// channels, collects their done flags and ends the run on completion or watchdog.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned NUM_CH     = 1,
    parameter bit          ALL_DONE   = 1'b1,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned CYC_W      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_restart,
    input  logic [NUM_CH-1:0]  in_done,
    output logic               out_core_reset,
    output logic [NUM_CH-1:0]  out_run,
    output logic               out_finish,
    output logic               out_timeout,
    output logic [CYC_W-1:0]   out_cycles,
    output logic [STATE_W-1:0] out_state
);

    localparam int unsigned HOLD_W    = hold_cnt_w(RST_CYCLES);
    localparam int unsigned RUN_W     = run_cnt_w(TIMEOUT);
    localparam int unsigned HOLD_LAST = (RST_CYCLES == 0) ? 0 : RST_CYCLES - 1;
    localparam int unsigned TMO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          WDOG_EN   = (TIMEOUT != 0);

    state_e              r_state,      w_state_nxt;
    logic [HOLD_W-1:0]   r_hold,       w_hold_nxt;
    logic [RUN_W-1:0]    r_run_cnt,    w_run_cnt_nxt;
    logic [NUM_CH-1:0]   r_latch,      w_latch_nxt;
    logic [NUM_CH-1:0]   r_run,        w_run_nxt;
    logic [CYC_W-1:0]    r_cycles,     w_cycles_nxt;
    logic                r_core_reset, w_core_reset_nxt;
    logic                r_finish,     w_finish_nxt;
    logic                r_timeout,    w_timeout_nxt;

    logic [NUM_CH-1:0]   w_seen;
    logic                w_complete;
    logic                w_expire;

    // A done sampled on the current edge counts alongside the latched ones.
    assign w_seen     = r_latch | in_done;
    assign w_complete = ALL_DONE ? (&w_seen) : (|w_seen);
    assign w_expire   = WDOG_EN && (r_run_cnt == RUN_W'(TMO_LAST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_hold       <= '0;
            r_run_cnt    <= '0;
            r_latch      <= '0;
            r_run        <= '0;
            r_cycles     <= '0;
            r_core_reset <= 1'b1;
            r_finish     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_run_cnt    <= w_run_cnt_nxt;
            r_latch      <= w_latch_nxt;
            r_run        <= w_run_nxt;
            r_cycles     <= w_cycles_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_finish     <= w_finish_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_run_cnt_nxt    = r_run_cnt;
        w_latch_nxt      = r_latch;
        w_run_nxt        = r_run;
        w_cycles_nxt     = r_cycles;
        w_core_reset_nxt = r_core_reset;
        w_finish_nxt     = 1'b0;
        w_timeout_nxt    = r_timeout;

        if (in_restart) begin
            // Abort from any state; in HOLD this simply restarts the hold count.
            w_state_nxt      = ST_HOLD;
            w_hold_nxt       = '0;
            w_run_cnt_nxt    = '0;
            w_latch_nxt      = '0;
            w_run_nxt        = '0;
            w_cycles_nxt     = '0;
            w_core_reset_nxt = 1'b1;
            w_timeout_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_latch_nxt   = '0;
                    w_cycles_nxt  = '0;
                    w_run_cnt_nxt = '0;
                    if (r_hold == HOLD_W'(HOLD_LAST)) begin
                        w_state_nxt      = ST_RUN;
                        w_hold_nxt       = '0;
                        w_core_reset_nxt = 1'b0;
                        w_run_nxt        = '1;
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    w_latch_nxt = w_seen;
                    if (r_cycles != '1) begin
                        w_cycles_nxt = r_cycles + CYC_W'(1);
                    end
                    if (WDOG_EN) begin
                        w_run_cnt_nxt = r_run_cnt + RUN_W'(1);
                    end
                    // Completion takes priority over a watchdog expiry on the same edge.
                    if (w_complete) begin
                        w_state_nxt   = ST_DONE;
                        w_run_nxt     = '0;
                        w_finish_nxt  = 1'b1;
                        w_timeout_nxt = 1'b0;
                    end else if (w_expire) begin
                        w_state_nxt   = ST_TMO;
                        w_run_nxt     = '0;
                        w_finish_nxt  = 1'b1;
                        w_timeout_nxt = 1'b1;
                    end
                end
                ST_DONE, ST_TMO: begin
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                end
            endcase
        end
    end

    assign out_core_reset = r_core_reset;
    assign out_run        = r_run;
    assign out_finish     = r_finish;
    assign out_timeout    = r_timeout;
    assign out_cycles     = r_cycles;
    assign out_state      = r_state;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: four instances cover single-channel,
// all/any multi-channel completion and a small-budget watchdog with a narrow cycle counter.
module tb_run_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic restart = 1'b0;
    logic [0:0] done_a = '0;
    logic [2:0] done3 = '0;
    logic [0:0] done_t = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic        a_core, a_fin, a_tmo;
    logic [0:0]  a_run;
    logic [31:0] a_cyc;
    logic [1:0]  a_st;

    logic        l_core, l_fin, l_tmo;
    logic [2:0]  l_run;
    logic [7:0]  l_cyc;
    logic [1:0]  l_st;

    logic        n_core, n_fin, n_tmo;
    logic [2:0]  n_run;
    logic [7:0]  n_cyc;
    logic [1:0]  n_st;

    logic        t_core, t_fin, t_tmo;
    logic [0:0]  t_run;
    logic [4:0]  t_cyc;
    logic [1:0]  t_st;

    run_sequencer #(.RST_CYCLES(4), .NUM_CH(1), .ALL_DONE(1'b1), .TIMEOUT(100000), .CYC_W(32)) u_a (
        .clock(clock), .reset(reset), .in_restart(restart), .in_done(done_a),
        .out_core_reset(a_core), .out_run(a_run), .out_finish(a_fin),
        .out_timeout(a_tmo), .out_cycles(a_cyc), .out_state(a_st));

    run_sequencer #(.RST_CYCLES(4), .NUM_CH(3), .ALL_DONE(1'b1), .TIMEOUT(0), .CYC_W(8)) u_all (
        .clock(clock), .reset(reset), .in_restart(restart), .in_done(done3),
        .out_core_reset(l_core), .out_run(l_run), .out_finish(l_fin),
        .out_timeout(l_tmo), .out_cycles(l_cyc), .out_state(l_st));

    run_sequencer #(.RST_CYCLES(4), .NUM_CH(3), .ALL_DONE(1'b0), .TIMEOUT(0), .CYC_W(8)) u_any (
        .clock(clock), .reset(reset), .in_restart(restart), .in_done(done3),
        .out_core_reset(n_core), .out_run(n_run), .out_finish(n_fin),
        .out_timeout(n_tmo), .out_cycles(n_cyc), .out_state(n_st));

    run_sequencer #(.RST_CYCLES(4), .NUM_CH(1), .ALL_DONE(1'b1), .TIMEOUT(50), .CYC_W(5)) u_tmo (
        .clock(clock), .reset(reset), .in_restart(restart), .in_done(done_t),
        .out_core_reset(t_core), .out_run(t_run), .out_finish(t_fin),
        .out_timeout(t_tmo), .out_cycles(t_cyc), .out_state(t_st));

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the bench just after an edge with reset released; the next edge is hold edge 1.
    task automatic do_reset;
        reset = 1'b1; restart = 1'b0; done_a = '0; done3 = '0; done_t = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (a_st !== 2'd0) begin n_fail++; $display("FAIL rst_a_state got=%0d exp=0", a_st); end
        n_checks++; if (a_core !== 1'b1) begin n_fail++; $display("FAIL rst_a_core got=%0b exp=1", a_core); end
        n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL rst_a_run got=%0b exp=0", a_run); end
        n_checks++; if (a_fin !== 1'b0) begin n_fail++; $display("FAIL rst_a_finish got=%0b exp=0", a_fin); end
        n_checks++; if (a_tmo !== 1'b0) begin n_fail++; $display("FAIL rst_a_timeout got=%0b exp=0", a_tmo); end
        n_checks++; if (a_cyc !== 32'd0) begin n_fail++; $display("FAIL rst_a_cycles got=%0d exp=0", a_cyc); end
        n_checks++; if (l_run !== 3'b000) begin n_fail++; $display("FAIL rst_all_run got=%0b exp=000", l_run); end
        n_checks++; if (t_core !== 1'b1) begin n_fail++; $display("FAIL rst_tmo_core got=%0b exp=1", t_core); end
    endtask

    task automatic test_hold_run_done;
        do_reset;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            n_checks++; if (a_core !== 1'b1 || a_run !== 1'b0 || a_st !== 2'd0) begin
                n_fail++; $display("FAIL t1_hold edge=%0d got core=%0b run=%0b st=%0d exp core=1 run=0 st=0", k, a_core, a_run, a_st);
            end
        end
        tick(1);
        n_checks++; if (a_core !== 1'b0 || a_run !== 1'b1 || a_st !== 2'd1) begin
            n_fail++; $display("FAIL t1_enter_run got core=%0b run=%0b st=%0d exp core=0 run=1 st=1", a_core, a_run, a_st);
        end
        n_checks++; if (a_cyc !== 32'd0) begin n_fail++; $display("FAIL t1_cycles_start got=%0d exp=0", a_cyc); end
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            n_checks++; if (a_cyc !== 32'(k)) begin n_fail++; $display("FAIL t1_cycles_count got=%0d exp=%0d", a_cyc, k); end
        end
        done_a = 1'b1;
        tick(1);
        done_a = 1'b0;
        n_checks++; if (a_fin !== 1'b1) begin n_fail++; $display("FAIL t1_finish got=%0b exp=1", a_fin); end
        n_checks++; if (a_cyc !== 32'd11) begin n_fail++; $display("FAIL t1_cycles_final got=%0d exp=11", a_cyc); end
        n_checks++; if (a_tmo !== 1'b0) begin n_fail++; $display("FAIL t1_timeout got=%0b exp=0", a_tmo); end
        n_checks++; if (a_run !== 1'b0 || a_st !== 2'd2) begin
            n_fail++; $display("FAIL t1_done_state got run=%0b st=%0d exp run=0 st=2", a_run, a_st);
        end
        tick(1);
        n_checks++; if (a_fin !== 1'b0) begin n_fail++; $display("FAIL t1_finish_single got=%0b exp=0", a_fin); end
        n_checks++; if (a_st !== 2'd2 || a_cyc !== 32'd11 || a_core !== 1'b0) begin
            n_fail++; $display("FAIL t1_done_hold got st=%0d cyc=%0d core=%0b exp st=2 cyc=11 core=0", a_st, a_cyc, a_core);
        end
    endtask

    task automatic test_multi_ch;
        logic [2:0] d;
        do_reset;
        tick(4);
        n_checks++; if (l_run !== 3'b111 || n_run !== 3'b111) begin
            n_fail++; $display("FAIL t2_run_all_ch got all=%0b any=%0b exp 111/111", l_run, n_run);
        end
        for (int c = 0; c <= 14; c++) begin
            d = (c == 5) ? 3'b001 : (c == 8) ? 3'b100 : (c == 12) ? 3'b010 : 3'b000;
            done3 = d;
            tick(1);
            n_checks++; if (n_fin !== 1'(c == 5)) begin n_fail++; $display("FAIL t2_any_finish cyc=%0d got=%0b exp=%0b", c, n_fin, (c == 5)); end
            n_checks++; if (l_fin !== 1'(c == 12)) begin n_fail++; $display("FAIL t2_all_finish cyc=%0d got=%0b exp=%0b", c, l_fin, (c == 12)); end
            n_checks++; if (l_run !== ((c < 12) ? 3'b111 : 3'b000)) begin
                n_fail++; $display("FAIL t2_all_run cyc=%0d got=%0b exp=%0b", c, l_run, ((c < 12) ? 3'b111 : 3'b000));
            end
        end
        done3 = 3'b000;
        n_checks++; if (n_cyc !== 8'd6 || n_st !== 2'd2) begin
            n_fail++; $display("FAIL t2_any_end got cyc=%0d st=%0d exp cyc=6 st=2", n_cyc, n_st);
        end
        n_checks++; if (l_cyc !== 8'd13 || l_st !== 2'd2 || l_tmo !== 1'b0) begin
            n_fail++; $display("FAIL t2_all_end got cyc=%0d st=%0d tmo=%0b exp cyc=13 st=2 tmo=0", l_cyc, l_st, l_tmo);
        end
    endtask

    task automatic test_timeout;
        do_reset;
        tick(4);
        tick(49);
        n_checks++; if (t_st !== 2'd1 || t_run !== 1'b1 || t_fin !== 1'b0) begin
            n_fail++; $display("FAIL t3_before_expiry got st=%0d run=%0b fin=%0b exp st=1 run=1 fin=0", t_st, t_run, t_fin);
        end
        n_checks++; if (t_cyc !== 5'd31) begin n_fail++; $display("FAIL t3_cycles_saturate got=%0d exp=31", t_cyc); end
        tick(1);
        n_checks++; if (t_st !== 2'd3 || t_fin !== 1'b1 || t_tmo !== 1'b1) begin
            n_fail++; $display("FAIL t3_expiry got st=%0d fin=%0b tmo=%0b exp st=3 fin=1 tmo=1", t_st, t_fin, t_tmo);
        end
        n_checks++; if (t_run !== 1'b0 || t_core !== 1'b0 || t_cyc !== 5'd31) begin
            n_fail++; $display("FAIL t3_tmo_outputs got run=%0b core=%0b cyc=%0d exp run=0 core=0 cyc=31", t_run, t_core, t_cyc);
        end
        tick(1);
        n_checks++; if (t_fin !== 1'b0 || t_tmo !== 1'b1 || t_st !== 2'd3) begin
            n_fail++; $display("FAIL t3_tmo_sticky got fin=%0b tmo=%0b st=%0d exp fin=0 tmo=1 st=3", t_fin, t_tmo, t_st);
        end
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_checks++; if (t_st !== 2'd0 || t_tmo !== 1'b0 || t_core !== 1'b1 || t_cyc !== 5'd0 || t_fin !== 1'b0) begin
            n_fail++; $display("FAIL t3_restart_from_tmo got st=%0d tmo=%0b core=%0b cyc=%0d fin=%0b exp 0/0/1/0/0",
                               t_st, t_tmo, t_core, t_cyc, t_fin);
        end
    endtask

    task automatic test_done_at_expiry;
        do_reset;
        tick(4);
        tick(49);
        done_t = 1'b1;
        tick(1);
        done_t = 1'b0;
        n_checks++; if (t_st !== 2'd2 || t_fin !== 1'b1) begin
            n_fail++; $display("FAIL t4_done_wins got st=%0d fin=%0b exp st=2 fin=1", t_st, t_fin);
        end
        n_checks++; if (t_tmo !== 1'b0 || t_run !== 1'b0) begin
            n_fail++; $display("FAIL t4_no_timeout got tmo=%0b run=%0b exp tmo=0 run=0", t_tmo, t_run);
        end
    endtask

    task automatic test_restart;
        do_reset;
        tick(4);
        tick(20);
        n_checks++; if (a_cyc !== 32'd20) begin n_fail++; $display("FAIL t5_cycles_before got=%0d exp=20", a_cyc); end
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_checks++; if (a_st !== 2'd0 || a_core !== 1'b1 || a_run !== 1'b0 || a_fin !== 1'b0 || a_cyc !== 32'd0) begin
            n_fail++; $display("FAIL t5_abort got st=%0d core=%0b run=%0b fin=%0b cyc=%0d exp 0/1/0/0/0",
                               a_st, a_core, a_run, a_fin, a_cyc);
        end
        tick(2);
        n_checks++; if (a_core !== 1'b1 || a_fin !== 1'b0) begin
            n_fail++; $display("FAIL t5_hold_mid got core=%0b fin=%0b exp core=1 fin=0", a_core, a_fin);
        end
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(3);
        n_checks++; if (a_core !== 1'b1 || a_st !== 2'd0) begin
            n_fail++; $display("FAIL t5_hold_restarted got core=%0b st=%0d exp core=1 st=0", a_core, a_st);
        end
        tick(1);
        n_checks++; if (a_core !== 1'b0 || a_run !== 1'b1 || a_st !== 2'd1 || a_cyc !== 32'd0) begin
            n_fail++; $display("FAIL t5_rerun got core=%0b run=%0b st=%0d cyc=%0d exp 0/1/1/0", a_core, a_run, a_st, a_cyc);
        end
        tick(1);
        n_checks++; if (a_cyc !== 32'd1) begin n_fail++; $display("FAIL t5_cycles_restart got=%0d exp=1", a_cyc); end
    endtask

    task automatic test_async_reset;
        do_reset;
        tick(4);
        tick(5);
        n_checks++; if (a_cyc !== 32'd5) begin n_fail++; $display("FAIL t6_cycles_pre got=%0d exp=5", a_cyc); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (a_st !== 2'd0 || a_core !== 1'b1 || a_run !== 1'b0) begin
            n_fail++; $display("FAIL t6_async got st=%0d core=%0b run=%0b exp st=0 core=1 run=0", a_st, a_core, a_run);
        end
        n_checks++; if (a_cyc !== 32'd0 || a_fin !== 1'b0 || a_tmo !== 1'b0) begin
            n_fail++; $display("FAIL t6_async_regs got cyc=%0d fin=%0b tmo=%0b exp 0/0/0", a_cyc, a_fin, a_tmo);
        end
        tick(1);
        reset = 1'b0;
        done_a = 1'b1;
        tick(3);
        n_checks++; if (a_st !== 2'd0 || a_core !== 1'b1) begin
            n_fail++; $display("FAIL t6_done_in_hold got st=%0d core=%0b exp st=0 core=1", a_st, a_core);
        end
        tick(1);
        done_a = 1'b0;
        n_checks++; if (a_st !== 2'd1 || a_run !== 1'b1) begin
            n_fail++; $display("FAIL t6_run_entry got st=%0d run=%0b exp st=1 run=1", a_st, a_run);
        end
        tick(1);
        n_checks++; if (a_st !== 2'd1 || a_fin !== 1'b0 || a_cyc !== 32'd1) begin
            n_fail++; $display("FAIL t6_latch_clear got st=%0d fin=%0b cyc=%0d exp st=1 fin=0 cyc=1", a_st, a_fin, a_cyc);
        end
    endtask

    initial begin
        test_reset;
        test_hold_run_done;
        test_multi_ch;
        test_timeout;
        test_done_at_expiry;
        test_restart;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
